// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and dump FSM state encoding for the data memory
package dmem_pkg;

  localparam int DMEM_AB    = 11;
  localparam int DMEM_DB    = 16;
  localparam int DMEM_DEPTH = 2048;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_e;

endpackage

// File: rtl/dmem_sp_ram.sv
// rtl/dmem_sp_ram.sv - single-port synchronous word RAM, registered read, no reset
module dmem_sp_ram #(
  parameter int AB    = 11,
  parameter int DB    = 16,
  parameter int DEPTH = 2048
) (
  input  logic          clk,
  input  logic [AB-1:0] addr,
  input  logic          we,
  input  logic [DB-1:0] wdata,
  output logic [DB-1:0] rdata
);

  logic [DB-1:0] mem [DEPTH];
  logic [DB-1:0] rdata_q;

  // Write on request; read register always follows the addressed word.
  // The caller keeps addr below DEPTH.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_dump.sv
// rtl/data_memory_dump.sv - CPU data RAM with a background debug dump streamer
module data_memory_dump
  import dmem_pkg::*;
#(
  parameter int AB       = DMEM_AB,
  parameter int DB       = DMEM_DB,
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int WR_FIRST = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RdRam,
  input  logic          WrRam,
  input  logic [AB-1:0] Addr,
  input  logic [DB-1:0] In_Data,
  output logic [DB-1:0] Out_Data,
  output logic          Out_Valid,
  input  logic          dump_start,
  input  logic [AB-1:0] dump_base,
  input  logic [AB:0]   dump_len,
  output logic [DB-1:0] dump_data,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic          dump_busy,
  output logic          dump_done
);

  localparam logic [AB:0]   DEPTH_W   = (AB+1)'(DEPTH);
  localparam logic [AB-1:0] LAST_ADDR = AB'(DEPTH - 1);
  localparam logic [AB:0]   ONE_W     = (AB+1)'(1);

  // CPU reads and writes are mutually exclusive, so a write-first read path is never needed.
  if (WR_FIRST != 0) begin : g_wr_first_unsupported
    $error("data_memory_dump: WR_FIRST must be 0");
  end

  // CPU port decode
  logic          cpu_active;
  logic          cpu_rd;
  logic          addr_in_range;
  logic [AB-1:0] ram_addr;
  logic          ram_we;
  logic [DB-1:0] ram_rdata;

  // CPU read-return registers
  logic          cpu_rd_q, cpu_rd_d;
  logic          cpu_oor_q, cpu_oor_d;
  logic [DB-1:0] out_hold_q, out_hold_d;
  logic [DB-1:0] out_data_c;

  // Dump engine registers
  dump_state_e   state_q, state_d;
  logic [AB-1:0] ptr_q, ptr_d;
  logic [AB:0]   cnt_q, cnt_d;
  logic [DB-1:0] dump_data_q, dump_data_d;
  logic          dump_valid_q, dump_valid_d;
  logic          dump_busy_q, dump_busy_d;
  logic          dump_done_q, dump_done_d;
  logic [AB-1:0] base_mod;
  logic [AB-1:0] ptr_next;

  assign cpu_active    = RdRam | WrRam;
  assign cpu_rd        = RdRam & ~WrRam;
  assign addr_in_range = ({1'b0, Addr} < DEPTH_W);
  assign ram_we        = WrRam & addr_in_range;

  // The CPU owns the port whenever it asks; otherwise the dump pointer is presented.
  // Out-of-range CPU addresses are steered to word 0 so the array is never overindexed.
  assign ram_addr = cpu_active ? (addr_in_range ? Addr : '0) : ptr_q;

  // A full power-of-two depth makes the base already in range.
  if (DEPTH == (1 << AB)) begin : g_base_full
    assign base_mod = dump_base;
  end else begin : g_base_mod
    assign base_mod = dump_base % AB'(DEPTH);
  end

  assign ptr_next = (ptr_q == LAST_ADDR) ? '0 : ptr_q + AB'(1);

  dmem_sp_ram #(
    .AB    (AB),
    .DB    (DB),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (In_Data),
    .rdata (ram_rdata)
  );

  // Out_Data shows the RAM word in the cycle after a CPU read and the held copy otherwise,
  // so dump traffic on the shared read register never leaks onto the CPU side.
  always_comb begin
    out_data_c = out_hold_q;
    if (cpu_rd_q) begin
      out_data_c = cpu_oor_q ? '0 : ram_rdata;
    end
  end

  // Next-state for the CPU read-return registers.
  always_comb begin
    cpu_rd_d   = cpu_rd;
    cpu_oor_d  = ~addr_in_range;
    out_hold_d = out_data_c;
  end

  // CPU read-return state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rd_q   <= 1'b0;
      cpu_oor_q  <= 1'b0;
      out_hold_q <= '0;
    end else begin
      cpu_rd_q   <= cpu_rd_d;
      cpu_oor_q  <= cpu_oor_d;
      out_hold_q <= out_hold_d;
    end
  end

  assign Out_Data  = out_data_c;
  assign Out_Valid = cpu_rd_q;

  // Dump FSM next-state and datapath: fetch only in CPU-idle cycles, capture, then hold until accepted.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    dump_data_d  = dump_data_q;
    dump_valid_d = dump_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dump_start) begin
          ptr_d   = base_mod;
          cnt_d   = dump_len;
          state_d = (dump_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!cpu_active) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        dump_data_d  = ram_rdata;
        dump_valid_d = 1'b1;
        state_d      = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (dump_valid_q && dump_ready) begin
          dump_valid_d = 1'b0;
          cnt_d        = cnt_q - ONE_W;
          ptr_d        = ptr_next;
          state_d      = (cnt_q == ONE_W) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    dump_busy_d = (state_d == ST_FETCH) || (state_d == ST_CAPTURE) || (state_d == ST_PRESENT);
    dump_done_d = (state_d == ST_DONE);
  end

  // Dump FSM state register; reset aborts a dump with no done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_busy_q  <= 1'b0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      dump_data_q  <= dump_data_d;
      dump_valid_q <= dump_valid_d;
      dump_busy_q  <= dump_busy_d;
      dump_done_q  <= dump_done_d;
    end
  end

  assign dump_data  = dump_data_q;
  assign dump_valid = dump_valid_q;
  assign dump_busy  = dump_busy_q;
  assign dump_done  = dump_done_q;

endmodule
